v_wb_packer: RTL and testbench
==============================

// Module: v_wb_packer
// PURPOSE
//  Result-side counterpart of the vector lanes: collects 32-bit lane results (v_alu or v_mul) one beat
//  per handshake and packs them into 128-bit words for vector register file writeback of register vd.
//  Emits up to VLEN/WB_W words per instruction, with byte enables honouring vl/vsew tail, then pulses done.
// PARAMETERS
//  VLEN   512  vector register width in bits (4 x 128-bit words)
//  ELEN   32   lane result width in bits (one beat)
//  WB_W   128  writeback word width in bits; BEATS_PER_WORD = WB_W/ELEN = 4, WORDS = VLEN/WB_W = 4
// PORTS
//  clk          in   1    clock, all state on rising edge
//  rst          in   1    synchronous reset, active-high
//  start        in   1    begin a writeback group; sampled only in IDLE
//  vd           in   5    destination register, captured on start
//  vl           in   7    element count 0..64, captured on start
//  vsew         in   3    000=8b, 001=16b, 010=32b; others illegal; captured on start
//  sel_mul      in   1    1: beats taken from result_vmul, 0: result_valu; captured on start
//  result_valu  in   32   ALU lane result
//  result_vmul  in   32   MUL lane result
//  res_valid    in   1    selected result beat valid
//  res_ready    out  1    beat accepted when res_valid && res_ready
//  wb_valid     out  1    writeback word valid; held with data stable until wb_ready
//  wb_ready     in   1    register file accepts word
//  wb_addr      out  5    = captured vd
//  wb_word      out  2    word index within vd, 0..WORDS-1
//  wb_data      out  128  packed word; beat k in bits [32k+31:32k], little-endian elements
//  wb_be        out  16   byte enables for wb_data
//  busy         out  1    high in COLLECT/DRAIN
//  done         out  1    one-cycle pulse after final word handshake (or after start with vl=0)
//  err          out  1    one-cycle pulse: illegal vsew or (vl<<vsew) > VLEN/8; start rejected
// BEHAVIOUR
//  - Reset: state=IDLE; res_ready, wb_valid, busy, done, err = 0; wb_data, wb_be, wb_word, wb_addr = 0.
//  - On accepted start: total_bytes = vl<<vsew; beats = ceil(total_bytes/4); beat/word counters cleared.
//  - States: IDLE -start&legal&beats>0-> COLLECT; IDLE -start&vl=0-> IDLE with done pulse next cycle;
//    IDLE -start&illegal-> IDLE with err pulse next cycle, no capture.
//    COLLECT -last beat accepted-> DRAIN; DRAIN -wb_valid&wb_ready-> IDLE, done pulses the next cycle.
//  - res_ready = (state==COLLECT) && !(wb_valid && !wb_ready); i.e. one output register, pass-through on
//    simultaneous word handshake and beat acceptance.
//  - Word completes on 4th beat of a word or on the last beat of the group (partial word); completed
//    word is registered: wb_valid rises the cycle after the completing beat (latency 1).
//  - Unfilled beats of a partial word are 0. wb_be = bytes [0..n-1] set where n = min(16, remaining bytes).
//  - wb_word increments per completed word; never exceeds WORDS-1 (guaranteed by legality check).
//  - start outside IDLE ignored. Beats offered outside COLLECT are not accepted.
//  - rst mid-operation: partial word and pending wb_valid discarded, no done pulse.
// CONFIGURATION
//  V_WB_TAIL_AGNOSTIC_EN defined: tail bytes of the final partial word written as all-ones and
//    wb_be=16'hFFFF for every word (tail-agnostic). Undefined (default): tail bytes 0 and masked by wb_be
//    (tail-undisturbed). Whole-word absence unchanged: words beyond the last are never emitted.
// STRUCTURE
//  - v_pkg: sew_e enum (SEW8/16/32), VLEN/ELEN/WB_W constants, wb_state_e {IDLE,COLLECT,DRAIN}.
//  - Sub-module v_wb_be_gen: combinational, remaining_bytes -> 16-bit wb_be (handles macro variant).
// TESTING
//  1. SEW=32, vl=16, 16 beats back-to-back, wb_ready=1 -> 4 words, wb_word 0..3, be=FFFF, done once.
//  2. SEW=8, vl=5, beats 32'h44332211, 32'h000000AA -> one word data=...AA_44332211, be=001F.
//  3. SEW=16, vl=10, 5 beats -> word0 be=FFFF, word1 be=000F with bits[127:32]=0; default macro.
//  4. wb_ready=0 for 6 cycles after word0 -> wb_data stable, res_ready low after 4 more beats, no loss.
//  5. vsew=3'b011 or SEW=32 vl=17 -> err pulse, busy stays 0; vl=0 -> done pulse, no wb_valid.
//  6. rst asserted after 6 beats of a 16-beat group -> all outputs 0 next cycle, next start works.

Source files
------------

// File: rtl/v_pkg.sv
// Shared types, sizing constants and helpers for the vector writeback packer.
package v_pkg;

  localparam int VLEN           = 512;
  localparam int ELEN           = 32;
  localparam int WB_W           = 128;
  localparam int BEATS_PER_WORD = WB_W / ELEN;
  localparam int WORDS          = VLEN / WB_W;
  localparam int VLEN_BYTES     = VLEN / 8;

  typedef enum logic [2:0] {
    SEW8  = 3'b000,
    SEW16 = 3'b001,
    SEW32 = 3'b010
  } sew_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } wb_state_e;

  // Forces every byte flagged in fill to all-ones, other bytes pass through.
  function automatic logic [127:0] fill_tail(input logic [127:0] data, input logic [15:0] fill);
    logic [127:0] res;
    res = data;
    for (int i = 0; i < 16; i++) begin
      if (fill[i]) begin
        res[8*i +: 8] = 8'hFF;
      end else begin
        res[8*i +: 8] = data[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/v_wb_be_gen.sv
// Byte-enable / tail-fill generator for one writeback word from the bytes still owed to vd.
// Build option: V_WB_TAIL_AGNOSTIC_EN selects tail-agnostic enables and all-ones tail fill.
module v_wb_be_gen (
  input  logic [6:0]  remaining_bytes,
  output logic [15:0] wb_be,
  output logic [15:0] tail_fill
);

  logic [15:0] byte_mask_s;

  // Thermometer mask: byte i belongs to the vector when i < remaining_bytes.
  always_comb begin
    byte_mask_s = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (7'(i) < remaining_bytes) begin
        byte_mask_s[i] = 1'b1;
      end else begin
        byte_mask_s[i] = 1'b0;
      end
    end
  end

`ifdef V_WB_TAIL_AGNOSTIC_EN
  assign wb_be     = 16'hFFFF;
  assign tail_fill = ~byte_mask_s;
`else
  assign wb_be     = byte_mask_s;
  assign tail_fill = 16'h0000;
`endif

endmodule

// File: rtl/v_wb_packer.sv
// Packs 32-bit lane results into 128-bit vector register writeback words with tail byte enables.
// Build option: define V_WB_TAIL_AGNOSTIC_EN for tail-agnostic writeback of the final partial word.
module v_wb_packer
  import v_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   vd,
  input  logic [6:0]   vl,
  input  logic [2:0]   vsew,
  input  logic         sel_mul,
  input  logic [31:0]  result_valu,
  input  logic [31:0]  result_vmul,
  input  logic         res_valid,
  output logic         res_ready,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [4:0]   wb_addr,
  output logic [1:0]   wb_word,
  output logic [127:0] wb_data,
  output logic [15:0]  wb_be,
  output logic         busy,
  output logic         done,
  output logic         err
);

  wb_state_e    state_r, state_nxt_s;
  logic         sel_mul_r;
  logic [4:0]   beats_left_r;
  logic [6:0]   bytes_left_r;
  logic [1:0]   beat_idx_r;
  logic [1:0]   word_idx_r;
  logic [127:0] acc_r;
  logic         wb_valid_r, busy_r, done_r, err_r;
  logic [4:0]   wb_addr_r;
  logic [1:0]   wb_word_r;
  logic [127:0] wb_data_r;
  logic [15:0]  wb_be_r;

  logic [8:0]   total_bytes_s;
  logic         sew_ok_s, legal_s, start_ok_s;
  logic [4:0]   start_beats_s;
  logic         res_ready_s, beat_fire_s, last_beat_s, word_done_s;
  logic [31:0]  beat_data_s;
  logic [127:0] word_s, word_out_s;
  logic [15:0]  be_s, tail_fill_s;

  v_wb_be_gen u_be_gen (
    .remaining_bytes (bytes_left_r),
    .wb_be           (be_s),
    .tail_fill       (tail_fill_s)
  );

  // Start decode: group size in bytes/beats and legality against the register width.
  always_comb begin
    total_bytes_s = 9'd0;
    sew_ok_s      = 1'b0;
    case (vsew)
      SEW8: begin
        total_bytes_s = {2'b00, vl};
        sew_ok_s      = 1'b1;
      end
      SEW16: begin
        total_bytes_s = {1'b0, vl, 1'b0};
        sew_ok_s      = 1'b1;
      end
      SEW32: begin
        total_bytes_s = {vl, 2'b00};
        sew_ok_s      = 1'b1;
      end
      default: begin
        total_bytes_s = 9'd0;
        sew_ok_s      = 1'b0;
      end
    endcase
    legal_s       = sew_ok_s && (total_bytes_s <= 9'(VLEN_BYTES));
    start_beats_s = 5'((total_bytes_s + 9'd3) >> 2);
    start_ok_s    = start && (state_r == IDLE);
  end

  // Beat acceptance and assembly; a stalled output word blocks new beats.
  always_comb begin
    res_ready_s = (state_r == COLLECT) && !(wb_valid_r && !wb_ready);
    beat_fire_s = res_ready_s && res_valid;
    last_beat_s = (beats_left_r == 5'd1);
    word_done_s = beat_fire_s && ((beat_idx_r == 2'd3) || last_beat_s);
    if (sel_mul_r) begin
      beat_data_s = result_vmul;
    end else begin
      beat_data_s = result_valu;
    end
    word_s = acc_r;
    word_s[{beat_idx_r, 5'd0} +: 32] = beat_data_s;
    word_out_s = fill_tail(word_s, tail_fill_s);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s && legal_s && (start_beats_s != 5'd0)) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (beat_fire_s && last_beat_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      DRAIN: begin
        if (wb_valid_r && wb_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Group context, word accumulator and registered writeback/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_mul_r    <= 1'b0;
      beats_left_r <= 5'd0;
      bytes_left_r <= 7'd0;
      beat_idx_r   <= 2'd0;
      word_idx_r   <= 2'd0;
      acc_r        <= 128'd0;
      wb_valid_r   <= 1'b0;
      wb_addr_r    <= 5'd0;
      wb_word_r    <= 2'd0;
      wb_data_r    <= 128'd0;
      wb_be_r      <= 16'h0000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= (state_nxt_s != IDLE);
      if (start_ok_s) begin
        if (!legal_s) begin
          err_r <= 1'b1;
        end else if (start_beats_s == 5'd0) begin
          done_r <= 1'b1;
        end else begin
          wb_addr_r    <= vd;
          sel_mul_r    <= sel_mul;
          beats_left_r <= start_beats_s;
          bytes_left_r <= total_bytes_s[6:0];
          beat_idx_r   <= 2'd0;
          word_idx_r   <= 2'd0;
          acc_r        <= 128'd0;
        end
      end
      if (beat_fire_s) begin
        beats_left_r <= beats_left_r - 5'd1;
        if (word_done_s) begin
          acc_r      <= 128'd0;
          beat_idx_r <= 2'd0;
          word_idx_r <= word_idx_r + 2'd1;
          wb_data_r  <= word_out_s;
          wb_be_r    <= be_s;
          wb_word_r  <= word_idx_r;
          if (bytes_left_r > 7'd16) begin
            bytes_left_r <= bytes_left_r - 7'd16;
          end else begin
            bytes_left_r <= 7'd0;
          end
        end else begin
          acc_r      <= word_s;
          beat_idx_r <= beat_idx_r + 2'd1;
        end
      end
      if (word_done_s) begin
        wb_valid_r <= 1'b1;
      end else if (wb_valid_r && wb_ready) begin
        wb_valid_r <= 1'b0;
      end
      if ((state_r == DRAIN) && wb_valid_r && wb_ready) begin
        done_r <= 1'b1;
      end
    end
  end

  assign res_ready = res_ready_s;
  assign wb_valid  = wb_valid_r;
  assign wb_addr   = wb_addr_r;
  assign wb_word   = wb_word_r;
  assign wb_data   = wb_data_r;
  assign wb_be     = wb_be_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_v_wb_packer.sv
// Directed self-checking bench for v_wb_packer: packing, tails, stalls, rejects and mid-group reset.
module tb_v_wb_packer;

  logic         clk = 1'b0;
  logic         rst, start, sel_mul, res_valid, res_ready, wb_valid, wb_ready, busy, done, err;
  logic [4:0]   vd, wb_addr;
  logic [6:0]   vl;
  logic [2:0]   vsew;
  logic [31:0]  result_valu, result_vmul;
  logic [1:0]   wb_word;
  logic [127:0] wb_data;
  logic [15:0]  wb_be;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [127:0] q_data[$];
  logic [15:0]  q_be[$];
  logic [1:0]   q_word[$];
  logic [4:0]   q_addr[$];
  logic [127:0] exp_w;

  v_wb_packer dut (
    .clk(clk), .rst(rst), .start(start), .vd(vd), .vl(vl), .vsew(vsew), .sel_mul(sel_mul),
    .result_valu(result_valu), .result_vmul(result_vmul), .res_valid(res_valid),
    .res_ready(res_ready), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_word(wb_word), .wb_data(wb_data), .wb_be(wb_be), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every word handshake and done pulse (pre-edge values).
  always @(posedge clk) begin
    if (wb_valid && wb_ready) begin
      q_data.push_back(wb_data);
      q_be.push_back(wb_be);
      q_word.push_back(wb_word);
      q_addr.push_back(wb_addr);
    end
    if (done) done_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    q_data.delete();
    q_be.delete();
    q_word.delete();
    q_addr.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [4:0] d, input logic [6:0] l, input logic [2:0] s,
                          input logic m);
    vd = d; vl = l; vsew = s; sel_mul = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic m);
    int k;
    result_valu = m ? ~d : d;
    result_vmul = m ? d : ~d;
    res_valid = 1'b1;
    #1;
    k = 0;
    while (!res_ready && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("beat_accept", 128'(k < 40), 128'd1);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_res_ready"}, 128'(res_ready), 128'd0);
    chk({tag, "_wb_valid"}, 128'(wb_valid), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_done"}, 128'(done), 128'd0);
    chk({tag, "_err"}, 128'(err), 128'd0);
    chk({tag, "_wb_data"}, wb_data, 128'd0);
    chk({tag, "_wb_be"}, 128'(wb_be), 128'd0);
    chk({tag, "_wb_word"}, 128'(wb_word), 128'd0);
    chk({tag, "_wb_addr"}, 128'(wb_addr), 128'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vd = 5'd0; vl = 7'd0; vsew = 3'd0; sel_mul = 1'b0;
    result_valu = 32'd0; result_vmul = 32'd0; res_valid = 1'b0; wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: SEW32, vl=16, four full words back-to-back
    clear_mon();
    do_start(5'd3, 7'd16, 3'b010, 1'b0);
    chk("t1_busy", 128'(busy), 128'd1);
    for (int i = 0; i < 16; i++) send_beat(32'hC0DE_0000 + 32'(i), 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_nwords", 128'(q_data.size()), 128'd4);
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) exp_w[32*k +: 32] = 32'hC0DE_0000 + 32'(4*w + k);
      chk("t1_data", q_data[w], exp_w);
      chk("t1_be", 128'(q_be[w]), 128'hFFFF);
      chk("t1_word", 128'(q_word[w]), 128'(w));
      chk("t1_addr", 128'(q_addr[w]), 128'd3);
    end
    chk("t1_done", 128'(done_cnt), 128'd1);
    chk("t1_busy_end", 128'(busy), 128'd0);

    // 2: SEW8, vl=5 from the MUL lane, single partial word
    clear_mon();
    do_start(5'd7, 7'd5, 3'b000, 1'b1);
    send_beat(32'h4433_2211, 1'b1);
    send_beat(32'h0000_00AA, 1'b1);
    repeat (3) @(negedge clk);
    chk("t2_nwords", 128'(q_data.size()), 128'd1);
`ifdef V_WB_TAIL_AGNOSTIC_EN
    chk("t2_data", q_data[0], 128'hFFFFFFFF_FFFFFFFF_FFFFFFAA_44332211);
    chk("t2_be", 128'(q_be[0]), 128'hFFFF);
`else
    chk("t2_data", q_data[0], 128'h00000000_00000000_000000AA_44332211);
    chk("t2_be", 128'(q_be[0]), 128'h001F);
`endif
    chk("t2_word", 128'(q_word[0]), 128'd0);
    chk("t2_addr", 128'(q_addr[0]), 128'd7);
    chk("t2_done", 128'(done_cnt), 128'd1);

    // 3: SEW16, vl=10 -> one full word and a one-beat tail word
    clear_mon();
    do_start(5'd9, 7'd10, 3'b001, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(32'h5A00_0000 + 32'(i), 1'b0);
    repeat (3) @(negedge clk);
    chk("t3_nwords", 128'(q_data.size()), 128'd2);
    chk("t3_data0", q_data[0], 128'h5A000003_5A000002_5A000001_5A000000);
    chk("t3_be0", 128'(q_be[0]), 128'hFFFF);
`ifdef V_WB_TAIL_AGNOSTIC_EN
    chk("t3_data1", q_data[1], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_5A000004);
    chk("t3_be1", 128'(q_be[1]), 128'hFFFF);
`else
    chk("t3_data1", q_data[1], 128'h00000000_00000000_00000000_5A000004);
    chk("t3_be1", 128'(q_be[1]), 128'h000F);
`endif
    chk("t3_word1", 128'(q_word[1]), 128'd1);
    chk("t3_done", 128'(done_cnt), 128'd1);

    // 4: word1 stalls 6 cycles after word0 is taken; no loss, data stable
    clear_mon();
    do_start(5'd12, 7'd16, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(32'h7700_0000 + 32'(i), 1'b0);
    @(negedge clk);
    wb_ready = 1'b0;
    for (int i = 4; i < 8; i++) send_beat(32'h7700_0000 + 32'(i), 1'b0);
    for (int s = 0; s < 6; s++) begin
      #1;
      chk("t4_res_ready", 128'(res_ready), 128'd0);
      chk("t4_wb_valid", 128'(wb_valid), 128'd1);
      chk("t4_wb_data", wb_data, 128'h77000007_77000006_77000005_77000004);
      chk("t4_wb_word", 128'(wb_word), 128'd1);
      @(negedge clk);
    end
    vsew = 3'b011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_start_ignored_err", 128'(err), 128'd0);
    chk("t4_still_busy", 128'(busy), 128'd1);
    wb_ready = 1'b1;
    for (int i = 8; i < 16; i++) send_beat(32'h7700_0000 + 32'(i), 1'b0);
    repeat (3) @(negedge clk);
    chk("t4_nwords", 128'(q_data.size()), 128'd4);
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) exp_w[32*k +: 32] = 32'h7700_0000 + 32'(4*w + k);
      chk("t4_data", q_data[w], exp_w);
      chk("t4_word", 128'(q_word[w]), 128'(w));
    end
    chk("t4_done", 128'(done_cnt), 128'd1);

    // 5: illegal sew, oversize group, empty group
    clear_mon();
    do_start(5'd1, 7'd4, 3'b011, 1'b0);
    chk("t5_err_sew", 128'(err), 128'd1);
    chk("t5_busy_sew", 128'(busy), 128'd0);
    @(negedge clk);
    chk("t5_err_pulse", 128'(err), 128'd0);
    do_start(5'd1, 7'd17, 3'b010, 1'b0);
    chk("t5_err_vl17", 128'(err), 128'd1);
    chk("t5_busy_vl17", 128'(busy), 128'd0);
    do_start(5'd1, 7'd0, 3'b000, 1'b0);
    chk("t5_done_vl0", 128'(done), 128'd1);
    chk("t5_err_vl0", 128'(err), 128'd0);
    chk("t5_busy_vl0", 128'(busy), 128'd0);
    repeat (3) @(negedge clk);
    chk("t5_nwords", 128'(q_data.size()), 128'd0);
    chk("t5_done_cnt", 128'(done_cnt), 128'd1);

    // 6: reset after 6 beats of a maximal SEW8 group, then a fresh group
    clear_mon();
    do_start(5'd20, 7'd64, 3'b000, 1'b0);
    chk("t6_busy", 128'(busy), 128'd1);
    chk("t6_err", 128'(err), 128'd0);
    for (int i = 0; i < 6; i++) send_beat(32'hD00D_0000 + 32'(i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("t6_rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_done", 128'(done_cnt), 128'd0);
    clear_mon();
    do_start(5'd21, 7'd4, 3'b010, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(32'hE000_0000 + 32'(i), 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_nwords", 128'(q_data.size()), 128'd1);
    chk("t6_data", q_data[0], 128'hE0000003_E0000002_E0000001_E0000000);
    chk("t6_be", 128'(q_be[0]), 128'hFFFF);
    chk("t6_addr", 128'(q_addr[0]), 128'd21);
    chk("t6_done", 128'(done_cnt), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
